// File: rtl/wb_csr_mem_bridge.sv
// Wishbone classic slave: byte-maskable CSR bank plus a forwarded memory window with timeout.
// Optional IRQ status register enabled by defining WB_CSR_MEM_BRIDGE_IRQ_EN.
module wb_csr_mem_bridge #(
    parameter logic [31:0] ADDR_OFFSET = 32'h3000_0000,
    parameter logic [31:0] ADDR_SPAN   = 32'h0001_0000,
    parameter int unsigned NUM_CSR     = 4,
    parameter logic [31:0] MEM_OFFSET  = 32'h0000_0040,
    parameter int unsigned MEM_AW      = 10,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    input  logic [3:0]             wb_sel_i,
    input  logic [31:0]            wb_adr_i,
    input  logic [31:0]            wb_dat_i,
    output logic                   wb_ack_o,
    output logic                   wb_err_o,
    output logic [31:0]            wb_dat_o,
    output logic [32*NUM_CSR-1:0]  csr_o,
    output logic [NUM_CSR-1:0]     csr_wr_o,
    input  logic [NUM_CSR-1:0]     csr_clr_i,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [MEM_AW-1:0]      mem_addr_o,
    output logic [3:0]             mem_be_o,
    output logic [31:0]            mem_wdata_o,
    input  logic [31:0]            mem_rdata_i,
    input  logic                   mem_ack_i,
    output logic                   irq_o
);

    localparam int unsigned CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [31:0] CSR_END = 32'(4 * NUM_CSR);
    localparam logic [32:0] MEM_END = {1'b0, MEM_OFFSET} + (33'd4 << MEM_AW);

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_MEM_WAIT, S_RESP} state_t;

    state_t state, state_nxt;

    logic [31:0]          adr_q, wdat_q;
    logic [3:0]           sel_q;
    logic                 we_q, abandon_q;
    logic [CNT_W-1:0]     cnt_q;

    logic [31:0]          adr_d, wdat_d;
    logic [3:0]           sel_d;
    logic                 we_d, abandon_d;
    logic [CNT_W-1:0]     cnt_d;
    logic                 ack_d, err_d, req_d, mwe_d;
    logic [31:0]          rdat_d, mwd_d;
    logic [MEM_AW-1:0]    maddr_d;
    logic [3:0]           mbe_d;
    logic [32*NUM_CSR-1:0] csr_d;
    logic [NUM_CSR-1:0]   csr_wr_d;

    logic [31:0] off, mem_off;
    logic        in_span, csr_hit, irq_hit, mem_hit, dec_err;
    logic        start, timeout_hit, abandon_now;

`ifdef WB_CSR_MEM_BRIDGE_IRQ_EN
    logic [1:0] irq_stat_q, irq_stat_d, stat_set, stat_clr;
`endif

    assign start       = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST));
    assign abandon_now = abandon_q | ~wb_cyc_i;

    // Address decode of the latched request
    always_comb begin
        off     = adr_q - ADDR_OFFSET;
        mem_off = off - MEM_OFFSET;
        in_span = (adr_q >= ADDR_OFFSET) && (off < ADDR_SPAN);
        csr_hit = in_span && (off < CSR_END);
`ifdef WB_CSR_MEM_BRIDGE_IRQ_EN
        irq_hit = in_span && (off == CSR_END);
`else
        irq_hit = 1'b0;
`endif
        mem_hit = in_span && (off >= MEM_OFFSET) && ({1'b0, off} < MEM_END);
        dec_err = (adr_q[1:0] != 2'b00) || !(csr_hit || irq_hit || mem_hit);
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) state <= S_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start) state_nxt = S_DECODE;
            S_DECODE:   state_nxt = (!dec_err && mem_hit) ? S_MEM_WAIT : S_RESP;
            S_MEM_WAIT: if (mem_ack_i || timeout_hit) state_nxt = abandon_now ? S_IDLE : S_RESP;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Next values of every registered output and datapath register
    always_comb begin
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        abandon_d = abandon_q;
        cnt_d     = cnt_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        rdat_d    = 32'h0;
        req_d     = mem_req_o;
        mwe_d     = mem_we_o;
        maddr_d   = mem_addr_o;
        mbe_d     = mem_be_o;
        mwd_d     = mem_wdata_o;
        csr_wr_d  = '0;
        csr_d     = csr_o;
`ifdef WB_CSR_MEM_BRIDGE_IRQ_EN
        stat_set  = 2'b00;
        stat_clr  = 2'b00;
`endif
        for (int k = 0; k < int'(NUM_CSR); k++) begin
            if (csr_clr_i[k]) csr_d[32*k +: 32] = 32'h0;
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    adr_d     = wb_adr_i;
                    wdat_d    = wb_dat_i;
                    sel_d     = wb_sel_i;
                    we_d      = wb_we_i;
                    abandon_d = 1'b0;
                end
            end
            S_DECODE: begin
                if (dec_err) begin
                    err_d = 1'b1;
`ifdef WB_CSR_MEM_BRIDGE_IRQ_EN
                    stat_set[1] = 1'b1;
`endif
                end else if (csr_hit) begin
                    ack_d = 1'b1;
                    for (int k = 0; k < int'(NUM_CSR); k++) begin
                        if (off[31:2] == 30'(k)) begin
                            if (we_q) begin
                                // Bus lanes override a same-edge clear
                                for (int b = 0; b < 4; b++) begin
                                    if (sel_q[b]) csr_d[32*k + 8*b +: 8] = wdat_q[8*b +: 8];
                                end
                                csr_wr_d[k] = |sel_q;
                            end else begin
                                rdat_d = csr_o[32*k +: 32];
                            end
                        end
                    end
`ifdef WB_CSR_MEM_BRIDGE_IRQ_EN
                end else if (irq_hit) begin
                    ack_d = 1'b1;
                    if (we_q) begin
                        if (sel_q[0]) stat_clr = wdat_q[1:0];
                    end else begin
                        rdat_d = {30'h0, irq_stat_q};
                    end
`endif
                end else begin
                    req_d   = 1'b1;
                    mwe_d   = we_q;
                    maddr_d = MEM_AW'(mem_off >> 2);
                    mbe_d   = sel_q;
                    mwd_d   = wdat_q;
                    cnt_d   = '0;
                end
            end
            S_MEM_WAIT: begin
                abandon_d = abandon_now;
                if (mem_ack_i) begin
                    req_d = 1'b0;
                    if (!abandon_now) begin
                        ack_d = 1'b1;
                        if (!we_q) rdat_d = mem_rdata_i;
                    end
                end else if (timeout_hit) begin
                    req_d = 1'b0;
`ifdef WB_CSR_MEM_BRIDGE_IRQ_EN
                    stat_set[0] = 1'b1;
`endif
                    if (!abandon_now) err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
`ifdef WB_CSR_MEM_BRIDGE_IRQ_EN
        irq_stat_d = (irq_stat_q & ~stat_clr) | stat_set;
`endif
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            adr_q       <= 32'h0;
            wdat_q      <= 32'h0;
            sel_q       <= 4'h0;
            we_q        <= 1'b0;
            abandon_q   <= 1'b0;
            cnt_q       <= '0;
            wb_ack_o    <= 1'b0;
            wb_err_o    <= 1'b0;
            wb_dat_o    <= 32'h0;
            csr_o       <= '0;
            csr_wr_o    <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_be_o    <= 4'h0;
            mem_wdata_o <= 32'h0;
        end else begin
            adr_q       <= adr_d;
            wdat_q      <= wdat_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            abandon_q   <= abandon_d;
            cnt_q       <= cnt_d;
            wb_ack_o    <= ack_d;
            wb_err_o    <= err_d;
            wb_dat_o    <= rdat_d;
            csr_o       <= csr_d;
            csr_wr_o    <= csr_wr_d;
            mem_req_o   <= req_d;
            mem_we_o    <= mwe_d;
            mem_addr_o  <= maddr_d;
            mem_be_o    <= mbe_d;
            mem_wdata_o <= mwd_d;
        end
    end

`ifdef WB_CSR_MEM_BRIDGE_IRQ_EN
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            irq_stat_q <= 2'b00;
            irq_o      <= 1'b0;
        end else begin
            irq_stat_q <= irq_stat_d;
            irq_o      <= |irq_stat_d;
        end
    end
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_csr_mem_bridge.sv
// Bench for wb_csr_mem_bridge: directed and random Wishbone transfers against a behavioural model.
module tb_wb_csr_mem_bridge;
    localparam int unsigned NUM_CSR = 4;
    localparam int unsigned MEM_AW  = 10;
    localparam int unsigned TIMEOUT = 255;
    localparam logic [31:0] BASE    = 32'h3000_0000;

    logic clk, rst_n, cyc, stb, we, ack, err, mem_req, mem_we, mem_ack, irq;
    logic [3:0] sel, mem_be;
    logic [31:0] adr, wdat, rdat, mem_wdata, mem_rdata;
    logic [32*NUM_CSR-1:0] csr;
    logic [NUM_CSR-1:0] csr_wr, csr_clr;
    logic [MEM_AW-1:0] mem_addr;

    wb_csr_mem_bridge #(
        .ADDR_OFFSET(BASE), .ADDR_SPAN(32'h0001_0000), .NUM_CSR(NUM_CSR),
        .MEM_OFFSET(32'h40), .MEM_AW(MEM_AW), .TIMEOUT(TIMEOUT)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_ack_o(ack), .wb_err_o(err),
        .wb_dat_o(rdat), .csr_o(csr), .csr_wr_o(csr_wr), .csr_clr_i(csr_clr),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack), .irq_o(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0, n_fail = 0;
    logic [31:0] csr_m [NUM_CSR];
    logic [1:0]  irq_m;

    // Results of the last transfer
    logic        r_ack, r_err, r_seen, r_mwe, r_req_end, r_post;
    logic [31:0] r_dat, r_mwd;
    logic [3:0]  r_mbe;
    logic [MEM_AW-1:0] r_maddr;
    logic [NUM_CSR-1:0] r_csrwr, r_csrwr_post;
    int          r_lat;

    int          cat, acc;
    logic [31:0] ra, rd, rm;
    logic [3:0]  rs;
    logic        rw;

    localparam int K_ERR = 0, K_CSR = 1, K_MEM = 2, K_IRQ = 3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int kind_of(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        if (a < BASE || o >= 32'h0001_0000 || a[1:0] != 2'b00) return K_ERR;
        if (o < 4 * NUM_CSR) return K_CSR;
`ifdef WB_CSR_MEM_BRIDGE_IRQ_EN
        if (o == 4 * NUM_CSR) return K_IRQ;
`endif
        if (o >= 32'h40 && o < 32'h40 + 4 * (1 << MEM_AW)) return K_MEM;
        return K_ERR;
    endfunction

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int mlat, input logic [31:0] mrd, input logic [NUM_CSR-1:0] clr);
        int mcnt = 0;
        r_ack = 0; r_err = 0; r_seen = 0; r_dat = 0; r_lat = -1; r_req_end = 1'bx;
        r_mwe = 0; r_mwd = 0; r_mbe = 0; r_maddr = 0; r_csrwr = 0;
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #1;
            if (mem_ack) mem_ack = 0;
            csr_clr = (i == 1) ? clr : '0;
            if (ack || err) begin
                r_ack = ack; r_err = err; r_dat = rdat; r_lat = i;
                r_req_end = mem_req; r_csrwr = csr_wr;
                break;
            end
            if (mem_req) begin
                if (!r_seen) begin
                    r_seen = 1; r_maddr = mem_addr; r_mwe = mem_we; r_mbe = mem_be; r_mwd = mem_wdata;
                end
                mcnt++;
                if (mlat > 0 && mcnt == mlat) begin mem_ack = 1; mem_rdata = mrd; end
            end
        end
        @(negedge clk);
        cyc = 0; stb = 0; csr_clr = '0;
        @(posedge clk); #1;
        r_post = ack | err; r_csrwr_post = csr_wr;
    endtask

    // Run one transfer, predict its outcome from the address map, then update the model
    task automatic do_check(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int mlat, input logic [31:0] mrd,
                            input logic [NUM_CSR-1:0] clr);
        int k = kind_of(a);
        int idx = int'((a - BASE) >> 2);
        logic e_ack = 1, e_err = 0, e_seen = 0;
        logic [31:0] e_dat = 0;
        int e_lat = 2;
        logic [NUM_CSR-1:0] e_wr = '0;
        if (k == K_ERR) begin e_ack = 0; e_err = 1; irq_m[1] = 1'b1; end
        else if (k == K_CSR) begin
            if (!w) e_dat = csr_m[idx];
            else if (s != 0) e_wr[idx] = 1'b1;
        end else if (k == K_IRQ) begin
            if (!w) e_dat = {30'h0, irq_m};
            else if (s[0]) irq_m = irq_m & ~d[1:0];
        end else begin
            e_seen = 1;
            if (mlat > 0) begin e_lat = 2 + mlat; if (!w) e_dat = mrd; end
            else begin e_lat = 2 + TIMEOUT; e_ack = 0; e_err = 1; irq_m[0] = 1'b1; end
        end
        xfer(w, a, d, s, mlat, mrd, clr);
        check({tag, ".ack"}, 32'(r_ack), 32'(e_ack));
        check({tag, ".err"}, 32'(r_err), 32'(e_err));
        check({tag, ".lat"}, 32'(r_lat), 32'(e_lat));
        check({tag, ".dat"}, r_dat, e_dat);
        check({tag, ".one_cycle"}, 32'(r_post), 32'h0);
        check({tag, ".csr_wr"}, 32'(r_csrwr), 32'(e_wr));
        check({tag, ".csr_wr_post"}, 32'(r_csrwr_post), 32'h0);
        check({tag, ".req_seen"}, 32'(r_seen), 32'(e_seen));
        if (e_seen) begin
            check({tag, ".mem_addr"}, 32'(r_maddr), (a - BASE - 32'h40) >> 2);
            check({tag, ".mem_we"}, 32'(r_mwe), 32'(w));
            check({tag, ".mem_be"}, 32'(r_mbe), 32'(s));
            if (w) check({tag, ".mem_wdata"}, r_mwd, d);
            check({tag, ".req_end"}, 32'(r_req_end), 32'h0);
        end
        for (int j = 0; j < int'(NUM_CSR); j++) if (clr[j]) csr_m[j] = 32'h0;
        if (k == K_CSR && w) for (int b = 0; b < 4; b++) if (s[b]) csr_m[idx][8*b +: 8] = d[8*b +: 8];
        for (int j = 0; j < int'(NUM_CSR); j++)
            check($sformatf("%s.csr%0d", tag, j), csr[32*j +: 32], csr_m[j]);
`ifdef WB_CSR_MEM_BRIDGE_IRQ_EN
        check({tag, ".irq"}, 32'(irq), 32'(|irq_m));
`else
        check({tag, ".irq"}, 32'(irq), 32'h0);
`endif
    endtask

    initial begin
        rst_n = 0; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;
        csr_clr = '0; mem_rdata = 0; mem_ack = 0; irq_m = 2'b00;
        for (int j = 0; j < int'(NUM_CSR); j++) csr_m[j] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.ack", 32'(ack), 0);
        check("rst.err", 32'(err), 0);
        check("rst.dat", rdat, 0);
        check("rst.req", 32'(mem_req), 0);
        check("rst.irq", 32'(irq), 0);
        check("rst.csr_wr", 32'(csr_wr), 0);
        for (int j = 0; j < int'(NUM_CSR); j++) check($sformatf("rst.csr%0d", j), csr[32*j +: 32], 0);
        @(negedge clk); rst_n = 1;

        do_check("wr_csr1", 1, BASE + 4, 32'hDEAD_BEEF, 4'hF, 0, 0, '0);
        do_check("wr_csr1_b0", 1, BASE + 4, 32'h0000_00AA, 4'h1, 0, 0, '0);
        do_check("rd_csr1", 0, BASE + 4, 0, 4'hF, 0, 0, '0);
        check("rd_csr1.value", r_dat, 32'hDEAD_BEAA);
        do_check("mem_rd", 0, BASE + 32'h48, 0, 4'hF, 3, 32'h1234, '0);
        check("mem_rd.addr2", 32'(r_maddr), 2);
        do_check("mem_wr", 1, BASE + 32'h80, 32'hCAFE_F00D, 4'h6, 1, 0, '0);
        do_check("mem_timeout", 0, BASE + 32'h44, 0, 4'hF, 0, 0, '0);
        check("mem_timeout.req_low", 32'(mem_req), 0);
        do_check("misalign", 0, BASE + 2, 0, 4'hF, 0, 0, '0);
        do_check("out_span", 0, 32'h3100_0000, 0, 4'hF, 0, 0, '0);
        do_check("below_base", 1, BASE - 4, 32'h1, 4'hF, 0, 0, '0);
        do_check("gap", 0, BASE + 32'h20, 0, 4'hF, 0, 0, '0);
        do_check("win_last", 0, BASE + 32'h103C, 0, 4'hF, 2, 32'h5555_AAAA, '0);
        do_check("win_end", 0, BASE + 32'h1040, 0, 4'hF, 1, 0, '0);
        do_check("sel0_wr", 1, BASE + 4, 32'hFFFF_FFFF, 4'h0, 0, 0, '0);
        do_check("clr_wr", 1, BASE + 4, 32'h5, 4'hF, 0, 0, 4'b0010);
        do_check("wr_csr2", 1, BASE + 8, 32'h1122_3344, 4'hF, 0, 0, '0);
        do_check("clr_wr_lane", 1, BASE + 8, 32'hAB00_0077, 4'h1, 0, 0, 4'b0100);
        do_check("clr_other", 1, BASE + 12, 32'h9999_0000, 4'hC, 0, 0, 4'b0010);
        do_check("last_csr", 0, BASE + 12, 0, 4'hF, 0, 0, '0);

        // Clear pulse while idle
        @(negedge clk); csr_clr = 4'b1000;
        @(negedge clk); csr_clr = '0; csr_m[3] = 32'h0;
        check("idle_clr.csr3", csr[96 +: 32], 0);

        // Master abandons a window transfer; no response may follow
        @(negedge clk); cyc = 1; stb = 1; we = 1; adr = BASE + 32'h60; wdat = 32'h77; sel = 4'hF;
        repeat (2) @(posedge clk);
        #1 check("abandon.req", 32'(mem_req), 1);
        @(negedge clk); cyc = 0; stb = 0;
        acc = 0;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            if (mem_ack) mem_ack = 0;
            if (i == 1) mem_ack = 1;
            if (ack || err) acc++;
            if (i == 2) check("abandon.req_drop", 32'(mem_req), 0);
        end
        check("abandon.no_resp", 32'(acc), 0);

        // Reset while waiting on memory
        @(negedge clk); cyc = 1; stb = 1; we = 0; adr = BASE + 32'h50; sel = 4'hF;
        repeat (4) @(posedge clk);
        #1 check("rst_mid.req_before", 32'(mem_req), 1);
        @(negedge clk); rst_n = 0;
        @(posedge clk); #1;
        check("rst_mid.req", 32'(mem_req), 0);
        check("rst_mid.ack", 32'(ack | err), 0);
        for (int j = 0; j < int'(NUM_CSR); j++) begin
            csr_m[j] = 32'h0;
            check($sformatf("rst_mid.csr%0d", j), csr[32*j +: 32], 0);
        end
        irq_m = 2'b00;
        @(negedge clk); rst_n = 1; cyc = 0; stb = 0;
        do_check("post_rst_rd", 0, BASE + 4, 0, 4'hF, 0, 0, '0);

        for (int t = 0; t < 60; t++) begin
            cat = int'($urandom_range(0, 6));
            case (cat)
                0, 1: ra = BASE + 4 * $urandom_range(0, NUM_CSR - 1);
                2, 3: ra = BASE + 32'h40 + 4 * $urandom_range(0, (1 << MEM_AW) - 1);
                4:    ra = BASE + 4 * $urandom_range(0, 3) + $urandom_range(1, 3);
                5:    ra = BASE + 4 * $urandom_range(NUM_CSR + 1, 15);
                default: ra = ($urandom_range(0, 1) == 1) ? BASE + 32'h0001_0000 + 4 * $urandom_range(0, 255)
                                                          : BASE - 4 * $urandom_range(1, 256);
            endcase
            rw = 1'($urandom_range(0, 1));
            rd = $urandom;
            rm = $urandom;
            rs = 4'($urandom_range(0, 15));
            do_check($sformatf("rnd%0d", t), rw, ra, rd, rs, int'($urandom_range(1, 4)), rm, '0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
